mac_accumulator: RTL
====================

// Module: mac_accumulator
// PURPOSE
//  Downstream consumer of the 6-lane data selector. Takes one 6-lane beat of signed Q8.8 data
//  and the matching 6-lane weight beat per valid cycle, multiplies lane-wise and sums the 6 lanes.
//  Accumulates ACC_LEN beats (96 inputs / 6 lanes = 16) into one hidden-unit result.
//  Emits OUT_N (24) saturated 16-bit results per layer pass, then pulses done.
// PARAMETERS
//  BIT_LENGTH  16  width of one data/weight/result word, signed Q(BIT_LENGTH-FRAC).FRAC
//  DATA_N      6   lanes per beat
//  FRAC        8   fractional bits; products are rescaled by >>> FRAC
//  ACC_LEN     16  beats per result (DATA_ALL/DATA_N)
//  OUT_N       24  results per pass (HID_LENGTH)
//  ACC_W       40  accumulator width (2*BIT_LENGTH + ceil(log2(DATA_N*ACC_LEN)) + margin)
// PORTS
//  clk           in   1                  single clock, rising edge
//  rst_n         in   1                  asynchronous active-low reset
//  run           in   1                  pass enable; low = synchronous clear
//  in_valid      in   1                  input_data/input_weight hold a beat this cycle
//  input_data    in   BIT_LENGTH*DATA_N  lane i = bits [16i+15:16i], signed
//  input_weight  in   BIT_LENGTH*DATA_N  lane-aligned weights, signed
//  output_data   out  BIT_LENGTH         saturated result, signed Q8.8
//  out_valid     out  1                  one-cycle pulse; output_data valid
//  done          out  1                  one-cycle pulse with the OUT_N-th out_valid
// BEHAVIOUR
//  - Reset (rst_n=0, async): every register cleared; output_data=0, out_valid=0, done=0,
//    state=IDLE, beat_cnt=0, out_cnt=0, accumulator=0, all pipeline valids=0.
//  - FSM: IDLE -> BUSY when run=1; BUSY -> IDLE when run=0.
//    On any edge with run=0: same clear as reset (synchronous), whatever the state.
//  - Pipeline (BUSY only; all stages advance every cycle, no stall):
//    S1: p[i] <= sext(data[i]) * sext(weight[i]), 2*BIT_LENGTH signed; v1 <= in_valid.
//    S2: s <= sum of p[0..5], sign-extended to ACC_W; v2 <= v1.
//    S3, when v2=1:
//      beat_cnt < ACC_LEN-1: acc <= acc + s; beat_cnt++.
//      beat_cnt == ACC_LEN-1: r = (acc + s) >>> FRAC (arithmetic);
//        output_data <= sat16(r); out_valid <= 1; acc <= 0; beat_cnt <= 0.
//        out_cnt == OUT_N-1: done <= 1; out_cnt <= 0; else out_cnt++.
//    v2=0 (bubble): acc and beat_cnt hold; nothing is counted.
//  - sat16: r > 32767 -> 16'h7FFF; r < -32768 -> 16'h8000; else r[15:0]. Truncation toward -inf.
//  - Latency: last beat sampled at edge k -> out_valid and output_data updated at edge k+3.
//  - out_valid/done high for exactly one cycle; output_data holds its last value until the
//    next result or a clear.
//  - Back-to-back results: beat 0 of the next result may be sampled on the cycle after the
//    previous result's last beat, with no gap. Pipelining preserves this.
//  - in_valid with run=0 is ignored. Beats in flight in S1/S2 when run falls are discarded.
//  - Pass wrap: after done, out_cnt=0 and the next ACC_LEN beats start result 0 of a new pass.
// TESTING
//  1. data=weight=16'h0100 on all lanes, 16 contiguous beats -> one out_valid,
//     output_data=16'h6000, 3 cycles after the last beat.
//  2. data=16'h7FFF, weight=16'h7FFF, 16 beats -> output_data=16'h7FFF.
//     weight=16'h8000 instead -> output_data=16'h8000.
//  3. Case 1 beats with in_valid low every other cycle -> identical result 16'h6000,
//     out_valid 3 cycles after the 16th valid beat.
//  4. 24*16 contiguous beats, lane 0 = 1.0, other lanes 0 -> 24 out_valid pulses spaced
//     16 cycles apart, each 16'h1000; done only with the 24th; then out_cnt=0.
//  5. run dropped after beat 9, raised again, 16 fresh beats (case 1 data) -> no out_valid
//     from the aborted group; result 16'h6000.
//  6. rst_n asserted mid-accumulation, between clock edges -> all outputs 0 immediately.
//     After release plus 16 beats: correct result, no residue from before the reset.

Source files
------------

// File: rtl/mac_if.sv
// Beat/result bus between the lane selector, the MAC accumulator and its consumer.
// The master drives run and the data/weight beats; the slave returns saturated results.
interface mac_if #(
  parameter int BIT_LENGTH = 16,
  parameter int DATA_N     = 6
);
  logic                         run;
  logic                         in_valid;
  logic [BIT_LENGTH*DATA_N-1:0] input_data;
  logic [BIT_LENGTH*DATA_N-1:0] input_weight;
  logic [BIT_LENGTH-1:0]        output_data;
  logic                         out_valid;
  logic                         done;

  modport master (
    output run, in_valid, input_data, input_weight,
    input  output_data, out_valid, done
  );

  modport slave (
    input  run, in_valid, input_data, input_weight,
    output output_data, out_valid, done
  );
endinterface

// File: rtl/mac_accumulator.sv
// Lane-wise signed Q8.8 multiply, 6-lane sum and ACC_LEN-beat accumulation into one
// saturated hidden-unit result; pulses done with the OUT_N-th result of a pass.
module mac_accumulator #(
  parameter int BIT_LENGTH = 16,
  parameter int DATA_N     = 6,
  parameter int FRAC       = 8,
  parameter int ACC_LEN    = 16,
  parameter int OUT_N      = 24,
  parameter int ACC_W      = 40
) (
  input  logic clk,
  input  logic rst_n,
  mac_if.slave bus
);

  localparam int BW     = BIT_LENGTH;
  localparam int PW     = 2 * BIT_LENGTH;
  localparam int BEAT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam int OUT_W  = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (BW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // All-zero is the cleared state, so reset and run=0 share one assignment.
  typedef struct packed {
    state_e                     state;
    logic                       v0;
    logic [BW*DATA_N-1:0]       data;
    logic [BW*DATA_N-1:0]       weight;
    logic                       v1;
    logic [DATA_N-1:0][PW-1:0]  prod;
    logic                       v2;
    logic [ACC_W-1:0]           sum;
    logic [ACC_W-1:0]           acc;
    logic [BEAT_W-1:0]          beat_cnt;
    logic [OUT_W-1:0]           out_cnt;
    logic [BW-1:0]              out_data;
    logic                       out_valid;
    logic                       done;
  } regs_t;

  regs_t                     regs_q;
  logic [DATA_N-1:0][PW-1:0] prod_d;
  logic signed [ACC_W-1:0]   sum_d;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W-1:0]   scaled_d;
  logic [BW-1:0]             sat_d;

  // NOTE: every always_comb output gets a default before any branch or loop, so no latch is inferred.
  always_comb begin
    prod_d = '0;
    sum_d  = '0;
    for (int i = 0; i < DATA_N; i++) begin
      prod_d[i] = PW'($signed(regs_q.data[BW*i +: BW])) *
                  PW'($signed(regs_q.weight[BW*i +: BW]));
      sum_d     = sum_d + ACC_W'($signed(regs_q.prod[i]));
    end
    acc_d    = $signed(regs_q.acc) + $signed(regs_q.sum);
    scaled_d = acc_d >>> FRAC;
    if (scaled_d > SAT_MAX) begin
      sat_d = {1'b0, {(BW-1){1'b1}}};
    end else if (scaled_d < SAT_MIN) begin
      sat_d = {1'b1, {(BW-1){1'b0}}};
    end else begin
      sat_d = scaled_d[BW-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else if (!bus.run) begin
      regs_q <= '0;
    end else begin
      case (regs_q.state)
        IDLE: regs_q.state <= BUSY;
        BUSY: begin
          // Input capture stage: a beat presented at edge k reaches the output at edge k+3.
          regs_q.v0     <= bus.in_valid;
          regs_q.data   <= bus.input_data;
          regs_q.weight <= bus.input_weight;
          regs_q.v1     <= regs_q.v0;
          regs_q.prod   <= prod_d;
          regs_q.v2     <= regs_q.v1;
          regs_q.sum    <= sum_d;

          regs_q.out_valid <= 1'b0;
          regs_q.done      <= 1'b0;
          if (regs_q.v2) begin
            if (regs_q.beat_cnt == BEAT_W'(ACC_LEN - 1)) begin
              regs_q.out_data  <= sat_d;
              regs_q.out_valid <= 1'b1;
              regs_q.acc       <= '0;
              regs_q.beat_cnt  <= '0;
              if (regs_q.out_cnt == OUT_W'(OUT_N - 1)) begin
                regs_q.done    <= 1'b1;
                regs_q.out_cnt <= '0;
              end else begin
                regs_q.out_cnt <= regs_q.out_cnt + 1'b1;
              end
            end else begin
              regs_q.acc      <= acc_d;
              regs_q.beat_cnt <= regs_q.beat_cnt + 1'b1;
            end
          end
        end
        default: regs_q <= '0;
      endcase
    end
  end

  assign bus.output_data = regs_q.out_data;
  assign bus.out_valid   = regs_q.out_valid;
  assign bus.done        = regs_q.done;

endmodule
